// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared main-memory port between the I-cache miss path and the
// D-cache miss/writeback path; D side wins by default, bounded by a streak counter.
module cache_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MAX_D_STREAK = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_wr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_done,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  input  logic              mem_stall,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] OWN_NONE   = 2'b00;
  localparam logic [1:0] OWN_I      = 2'b01;
  localparam logic [1:0] OWN_D      = 2'b10;
  localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

  state_t     state;
  logic [3:0] streak;

  // mem_addr/mem_wr/mem_wdata double as the latched transaction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= '0;
      owner     <= OWN_NONE;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
      ic_done   <= 1'b0;
      dc_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dc_req && (!ic_req || streak < MAX_STREAK)) begin
            owner     <= OWN_D;
            mem_req   <= 1'b1;
            mem_wr    <= dc_wr;
            mem_addr  <= dc_addr;
            mem_wdata <= dc_wdata;
            streak    <= ic_req ? streak + 4'd1 : '0;
            state     <= ISSUE;
          end else if (ic_req) begin
            owner     <= OWN_I;
            mem_req   <= 1'b1;
            mem_wr    <= 1'b0;
            mem_addr  <= ic_addr;
            mem_wdata <= '0;
            streak    <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!mem_stall) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_done) begin
            if (owner == OWN_I) begin
              ic_rdata <= mem_rdata;
              ic_done  <= 1'b1;
            end else begin
              if (!mem_wr) dc_rdata <= mem_rdata;
              dc_done <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          ic_done <= 1'b0;
          dc_done <= 1'b0;
          owner   <= OWN_NONE;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
